// File: rtl/seq_counter_bank.sv
// rtl/seq_counter_bank.sv - bank of independent load/step/direction counters with terminal-count pulses
//
// Purpose:
//   CHANNELS independent WIDTH-bit counters. Each channel can be cleared,
//   loaded (the load value is stepped once before it is registered), or
//   enabled to step up or down by STEP. Overflow and underflow either wrap
//   (SATURATE=0) or clamp at 0 / 2^WIDTH-1 (SATURATE=1). A registered
//   terminal-count pulse follows every step that overflowed or underflowed.
//
// Parameters:
//   WIDTH     bits per channel counter
//   CHANNELS  number of channels
//   STEP      step magnitude, 1 .. 2^WIDTH-1
//   SATURATE  0 = modular wrap, 1 = clamp at the limits
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   clr         in   [CHANNELS]        per-channel synchronous clear (highest priority)
//   load        in   [CHANNELS]        per-channel load strobe
//   count_in    in   [CHANNELS*WIDTH]  load values, channel i at [i*WIDTH +: WIDTH]
//   en          in   [CHANNELS]        per-channel count enable
//   dir         in   [CHANNELS]        0 = up, 1 = down
//   count_out   out  [CHANNELS*WIDTH]  registered counts, same packing as count_in
//   tc          out  [CHANNELS]        registered terminal-count pulse
//   ovf_sticky  out  [CHANNELS]        sticky overflow/underflow status
//   sticky_clr  in                     clears every ovf_sticky bit
//
// Optional feature:
//   SEQ_COUNTER_STICKY_OVF_EN - when defined, ovf_sticky[i] latches every
//   terminal-count event until sticky_clr or reset (a new event wins over
//   sticky_clr at the same edge; clr[i] leaves it alone). When undefined,
//   ovf_sticky is constant 0, sticky_clr is ignored and no sticky flops exist.

module seq_counter_bank #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] count_in,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf_sticky,
  input  logic                      sticky_clr
);

  // Step in the counter width and in the one-bit-wider arithmetic width.
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;

    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] diff_dn;
    logic             ovf;
    logic             udf;
    logic             step_act;
    logic             evt;
    logic [WIDTH-1:0] stepped;

    always_comb begin
      // A load steps from the supplied value; an enable steps from the count.
      base     = load[g] ? count_in[g*WIDTH +: WIDTH] : cnt_q;
      step_act = load[g] | en[g];

      sum_up   = {1'b0, base} + STEP_W;
      diff_dn  = base - STEP_N;
      ovf      = sum_up[WIDTH];
      udf      = ({1'b0, base} < STEP_W);

      evt      = step_act & (dir[g] ? udf : ovf);

      stepped  = dir[g] ? diff_dn : sum_up[WIDTH-1:0];
      if ((SATURATE != 0) && evt) begin
        stepped = dir[g] ? '0 : MAX_V;
      end

      cnt_d = cnt_q;
      tc_d  = 1'b0;
      if (clr[g]) begin
        cnt_d = '0;
      end else if (step_act) begin
        cnt_d = stepped;
        tc_d  = evt;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        tc_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        tc_q  <= tc_d;
      end
    end

    assign count_out[g*WIDTH +: WIDTH] = cnt_q;
    assign tc[g]                       = tc_q;

`ifdef SEQ_COUNTER_STICKY_OVF_EN
    logic sticky_q;
    logic sticky_d;

    // Set dominates the global clear so an event coinciding with it is kept.
    assign sticky_d = tc_d | (sticky_q & ~sticky_clr);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_d;
      end
    end

    assign ovf_sticky[g] = sticky_q;
`endif
  end

`ifndef SEQ_COUNTER_STICKY_OVF_EN
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign ovf_sticky        = '0;
`endif

endmodule

// File: tb/tb_seq_counter_bank.sv
// tb/tb_seq_counter_bank.sv - directed self-checking bench for seq_counter_bank

module tb_seq_counter_bank;

  logic        clk;
  logic        reset;

  // Default instance: WIDTH=3, CHANNELS=4, STEP=1, wrap.
  logic [3:0]  clr, load, en, dir;
  logic [11:0] count_in;
  logic        sticky_clr;
  logic [11:0] count_out;
  logic [3:0]  tc;
  logic [3:0]  ovf_sticky;

  // Saturating instance: STEP=2.
  logic [3:0]  s_clr, s_load, s_en, s_dir;
  logic [11:0] s_count_in;
  logic        s_sticky_clr;
  logic [11:0] s_count_out;
  logic [3:0]  s_tc;
  logic [3:0]  s_ovf_sticky;

  int n_cmp;
  int n_fail;

`ifdef SEQ_COUNTER_STICKY_OVF_EN
  logic sticky_on = 1'b1;
`else
  logic sticky_on = 1'b0;
`endif

  seq_counter_bank #(.WIDTH(3), .CHANNELS(4), .STEP(1), .SATURATE(0)) u_dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .count_in(count_in),
    .en(en), .dir(dir), .count_out(count_out), .tc(tc),
    .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr)
  );

  seq_counter_bank #(.WIDTH(3), .CHANNELS(4), .STEP(2), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .clr(s_clr), .load(s_load), .count_in(s_count_in),
    .en(s_en), .dir(s_dir), .count_out(s_count_out), .tc(s_tc),
    .ovf_sticky(s_ovf_sticky), .sticky_clr(s_sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    load[0] = 1'b1;
    count_in[2:0] = 3'd3;
    en = 4'hF;
    tick();
    tick();
    n_cmp++;
    if (count_out !== 12'h000) begin
      n_fail++; $display("FAIL reset_count: got %h want 000", count_out);
    end
    n_cmp++;
    if (tc !== 4'h0) begin
      n_fail++; $display("FAIL reset_tc: got %b want 0000", tc);
    end
    n_cmp++;
    if (ovf_sticky !== 4'h0) begin
      n_fail++; $display("FAIL reset_sticky: got %b want 0000", ovf_sticky);
    end
    n_cmp++;
    if (s_count_out !== 12'h000 || s_tc !== 4'h0) begin
      n_fail++; $display("FAIL reset_sat: got %h/%b want 000/0000", s_count_out, s_tc);
    end
    load = 4'h0;
    en = 4'h0;
    reset = 1'b0;
  endtask

  task automatic test_load();
    count_in[2:0] = 3'd3;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    n_cmp++;
    if (count_out[2:0] !== 3'd4) begin
      n_fail++; $display("FAIL load_ch0: got %0d want 4", count_out[2:0]);
    end
    n_cmp++;
    if (tc !== 4'h0) begin
      n_fail++; $display("FAIL load_tc: got %b want 0000", tc);
    end
    n_cmp++;
    if (count_out[11:3] !== 9'h0) begin
      n_fail++; $display("FAIL load_others: got %h want 000", count_out[11:3]);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_c [4];
    logic       exp_t [4];
    exp_c[0] = 3'd7; exp_t[0] = 1'b0;
    exp_c[1] = 3'd0; exp_t[1] = 1'b1;
    exp_c[2] = 3'd1; exp_t[2] = 1'b0;
    exp_c[3] = 3'd1; exp_t[3] = 1'b0;
    count_in[5:3] = 3'd6;
    load[1] = 1'b1;
    en[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      load[1] = 1'b0;
      if (i == 2) en[1] = 1'b0;
      n_cmp++;
      if (count_out[5:3] !== exp_c[i] || tc[1] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got %0d tc=%b want %0d tc=%b",
                 i, count_out[5:3], tc[1], exp_c[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    count_in[8:6] = 3'd0;
    dir[2] = 1'b1;
    load[2] = 1'b1;
    tick();
    load[2] = 1'b0;
    dir[2] = 1'b0;
    n_cmp++;
    if (count_out[8:6] !== 3'd7 || tc[2] !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap: got %0d tc=%b want 7 tc=1", count_out[8:6], tc[2]);
    end
    tick();
    n_cmp++;
    if (count_out[8:6] !== 3'd7 || tc[2] !== 1'b0) begin
      n_fail++; $display("FAIL down_hold: got %0d tc=%b want 7 tc=0", count_out[8:6], tc[2]);
    end
  endtask

  task automatic test_priority();
    count_in[11:9] = 3'd2;
    clr[3] = 1'b1;
    load[3] = 1'b1;
    en[3] = 1'b1;
    tick();
    clr[3] = 1'b0;
    n_cmp++;
    if (count_out[11:9] !== 3'd0 || tc[3] !== 1'b0) begin
      n_fail++; $display("FAIL prio_clr: got %0d tc=%b want 0 tc=0", count_out[11:9], tc[3]);
    end
    tick();
    load[3] = 1'b0;
    en[3] = 1'b0;
    n_cmp++;
    if (count_out[11:9] !== 3'd3 || tc[3] !== 1'b0) begin
      n_fail++; $display("FAIL prio_load_en: got %0d tc=%b want 3 tc=0", count_out[11:9], tc[3]);
    end
  endtask

  task automatic test_independent();
    // ch0 4->5 up, ch1 1->0 down, ch2 load 7 up -> 0 with tc, ch3 clear.
    en[0] = 1'b1;
    en[1] = 1'b1; dir[1] = 1'b1;
    count_in[8:6] = 3'd7; load[2] = 1'b1;
    clr[3] = 1'b1;
    tick();
    en = 4'h0; dir = 4'h0; load = 4'h0; clr = 4'h0;
    n_cmp++;
    if (count_out !== 12'h005) begin
      n_fail++; $display("FAIL indep_count: got %h want 005", count_out);
    end
    n_cmp++;
    if (tc !== 4'b0100) begin
      n_fail++; $display("FAIL indep_tc: got %b want 0100", tc);
    end
  endtask

  task automatic test_dir_idle();
    dir = 4'hF;
    tick();
    dir = 4'h0;
    tick();
    n_cmp++;
    if (count_out !== 12'h005 || tc !== 4'h0) begin
      n_fail++; $display("FAIL dir_idle: got %h tc=%b want 005 tc=0000", count_out, tc);
    end
  endtask

  task automatic test_async_reset();
    en[0] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (count_out[2:0] !== 3'd7) begin
      n_fail++; $display("FAIL areset_pre: got %0d want 7", count_out[2:0]);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (count_out !== 12'h000 || tc !== 4'h0) begin
      n_fail++; $display("FAIL areset_immediate: got %h tc=%b want 000 tc=0000", count_out, tc);
    end
    tick();
    tick();
    n_cmp++;
    if (count_out !== 12'h000) begin
      n_fail++; $display("FAIL areset_hold: got %h want 000", count_out);
    end
    #3;
    reset = 1'b0;
    tick();
    en[0] = 1'b0;
    n_cmp++;
    if (count_out !== 12'h001 || tc !== 4'h0) begin
      n_fail++; $display("FAIL areset_release: got %h tc=%b want 001 tc=0000", count_out, tc);
    end
  endtask

  task automatic test_sticky();
    logic [3:0] exp_s;
    exp_s = {2'b00, sticky_on, 1'b0};
    count_in[5:3] = 3'd7;
    load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    n_cmp++;
    if (count_out[5:3] !== 3'd0 || tc[1] !== 1'b1 || ovf_sticky !== exp_s) begin
      n_fail++; $display("FAIL sticky_set: got %0d tc=%b s=%b want 0 tc=1 s=%b",
                         count_out[5:3], tc[1], ovf_sticky, exp_s);
    end
    tick();
    n_cmp++;
    if (tc[1] !== 1'b0 || ovf_sticky !== exp_s) begin
      n_fail++; $display("FAIL sticky_persist: got tc=%b s=%b want tc=0 s=%b", tc[1], ovf_sticky, exp_s);
    end
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    n_cmp++;
    if (ovf_sticky !== exp_s) begin
      n_fail++; $display("FAIL sticky_vs_clr: got %b want %b", ovf_sticky, exp_s);
    end
    sticky_clr = 1'b1;
    tick();
    n_cmp++;
    if (ovf_sticky !== 4'h0) begin
      n_fail++; $display("FAIL sticky_clear: got %b want 0000", ovf_sticky);
    end
    load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    sticky_clr = 1'b0;
    n_cmp++;
    if (ovf_sticky !== exp_s || tc[1] !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set_wins: got s=%b tc=%b want s=%b tc=1", ovf_sticky, tc[1], exp_s);
    end
    tick();
    n_cmp++;
    if (ovf_sticky !== exp_s) begin
      n_fail++; $display("FAIL sticky_after: got %b want %b", ovf_sticky, exp_s);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_c [8];
    logic       exp_t [8];
    exp_c[0] = 3'd7; exp_t[0] = 1'b0;
    exp_c[1] = 3'd7; exp_t[1] = 1'b1;
    exp_c[2] = 3'd5; exp_t[2] = 1'b0;
    exp_c[3] = 3'd3; exp_t[3] = 1'b0;
    exp_c[4] = 3'd1; exp_t[4] = 1'b0;
    exp_c[5] = 3'd0; exp_t[5] = 1'b1;
    exp_c[6] = 3'd0; exp_t[6] = 1'b1;
    exp_c[7] = 3'd0; exp_t[7] = 1'b0;
    s_count_in[8:6] = 3'd5;
    s_load[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      s_load[2] = 1'b0;
      s_en[2] = (i < 6);
      s_dir[2] = (i >= 1);
      n_cmp++;
      if (s_count_out[8:6] !== exp_c[i] || s_tc[2] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL sat_step%0d: got %0d tc=%b want %0d tc=%b",
                 i, s_count_out[8:6], s_tc[2], exp_c[i], exp_t[i]);
      end
    end
    n_cmp++;
    if (s_count_out[5:0] !== 6'h0 || s_count_out[11:9] !== 3'h0 || s_ovf_sticky[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL sat_others: got %h want ch0/1/3 zero", s_count_out);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    clr = '0; load = '0; en = '0; dir = '0; count_in = '0; sticky_clr = 1'b0;
    s_clr = '0; s_load = '0; s_en = '0; s_dir = '0; s_count_in = '0; s_sticky_clr = 1'b0;

    test_reset();
    test_load();
    test_wrap();
    test_down_wrap();
    test_priority();
    test_independent();
    test_dir_idle();
    test_async_reset();
    test_sticky();
    test_saturate();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
